// File: rtl/morse_symbol_gen.sv
// Morse letter generator: sends 'S' (three dots) or 'O' (three dashes) on Pin_Out.
// It then pulses the matching done line for one cycle after the trailing gap.
module morse_symbol_gen #(
    parameter int unsigned UNIT_CYCLES = 20_000_000,
    parameter int unsigned DOT_UNITS   = 1,
    parameter int unsigned DASH_UNITS  = 3,
    parameter int unsigned GAP_UNITS   = 1,
    parameter int unsigned TAIL_UNITS  = 3
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic S_Start_Sig,
    input  logic O_Start_Sig,
    output logic S_Done_Sig,
    output logic O_Done_Sig,
    output logic Pin_Out,
    output logic Busy_Sig
);

    // Each value is the phase length in clocks minus one. The phase ends when the timer reads 0.
    localparam logic [31:0] DOT_LOAD  = 32'(DOT_UNITS  * UNIT_CYCLES - 1);
    localparam logic [31:0] DASH_LOAD = 32'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [31:0] GAP_LOAD  = 32'(GAP_UNITS  * UNIT_CYCLES - 1);
    localparam logic [31:0] TAIL_LOAD = 32'(TAIL_UNITS * UNIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, MARK, SPACE, TAIL, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] timer, timer_nxt;
    logic [1:0]  elem, elem_nxt;
    logic        is_s, is_s_nxt;
    logic        pin_nxt, busy_nxt, s_done_nxt, o_done_nxt;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            timer      <= '0;
            elem       <= '0;
            is_s       <= 1'b0;
            Pin_Out    <= 1'b0;
            Busy_Sig   <= 1'b0;
            S_Done_Sig <= 1'b0;
            O_Done_Sig <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            elem       <= elem_nxt;
            is_s       <= is_s_nxt;
            Pin_Out    <= pin_nxt;
            Busy_Sig   <= busy_nxt;
            S_Done_Sig <= s_done_nxt;
            O_Done_Sig <= o_done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = (timer != 32'd0) ? timer - 32'd1 : timer;
        elem_nxt  = elem;
        is_s_nxt  = is_s;
        case (state)
            IDLE: begin
                // 'S' has priority when both requests are present.
                if (S_Start_Sig || O_Start_Sig) begin
                    is_s_nxt  = S_Start_Sig;
                    state_nxt = MARK;
                    timer_nxt = S_Start_Sig ? DOT_LOAD : DASH_LOAD;
                    elem_nxt  = 2'd0;
                end
            end
            MARK: begin
                if (timer == 32'd0) begin
                    if (elem < 2'd2) begin
                        state_nxt = SPACE;
                        timer_nxt = GAP_LOAD;
                    end else begin
                        state_nxt = TAIL;
                        timer_nxt = TAIL_LOAD;
                    end
                end
            end
            SPACE: begin
                if (timer == 32'd0) begin
                    elem_nxt  = elem + 2'd1;
                    state_nxt = MARK;
                    timer_nxt = is_s ? DOT_LOAD : DASH_LOAD;
                end
            end
            TAIL: begin
                if (timer == 32'd0)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Outputs are decoded from the next state so that they leave the flops together with it.
        pin_nxt    = (state_nxt == MARK);
        busy_nxt   = (state_nxt != IDLE);
        s_done_nxt = (state_nxt == DONE) &&  is_s_nxt;
        o_done_nxt = (state_nxt == DONE) && !is_s_nxt;
    end

endmodule
